mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 52 +++++
 rtl/mem_access_load_ext.sv | 29 ++
 rtl/mem_access.sv | 180 ++++++++++++++++++
 tb/tb_mem_access.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared types and constants for the byte-serial memory access
//               stage: FSM state encoding, funct3 size/sign codes and small
//               helpers that decode transfer length and align load data.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    // Memory-stage sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STORE = 2'd1,
        ST_LOAD  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    // funct3 size/sign codes for loads and stores.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Index of the last byte of a transfer: x00 -> 1 byte, x01 -> 2 bytes,
    // everything else (W and the undefined codes) -> 4 bytes.
    function automatic logic [1:0] last_byte_idx(input logic [2:0] funct3);
        logic [1:0] idx;
        case (funct3[1:0])
            2'b00:   idx = 2'd0;
            2'b01:   idx = 2'd1;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Load bytes enter the shift register from the top, so a short load ends
    // up in the upper bytes; move it down to bit 0 before extension.
    function automatic logic [31:0] align_load(input logic [31:0] shreg,
                                               input logic [1:0]  last_idx);
        logic [31:0] raw;
        case (last_idx)
            2'd0:    raw = {24'h000000, shreg[31:24]};
            2'd1:    raw = {16'h0000, shreg[31:16]};
            default: raw = shreg;
        endcase
        return raw;
    endfunction

endpackage : mem_access_pkg
`default_nettype wire

// File: rtl/mem_access_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : load_ext
// Description : Combinational sign/zero extension of raw load data according
//               to the funct3 size/sign code.
// Revision    : 1.0 - initial release
// ============================================================================
module load_ext
    import mem_access_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    // Extend byte/halfword loads; word and undefined codes pass unchanged.
    always_comb begin
        result = raw;
        case (funct3)
            F3_B:    result = {{24{raw[7]}}, raw[7:0]};
            F3_H:    result = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   result = {24'h000000, raw[7:0]};
            F3_HU:   result = {16'h0000, raw[15:0]};
            default: result = raw;
        endcase
    end

endmodule : load_ext
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : Memory-access pipeline stage driving a byte-wide RAM. Loads
//               and stores of 1/2/4 bytes are serialised one byte per cycle
//               (little-endian); ALU results pass straight to writeback.
//               The pipeline is stalled in every state except IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    // request from the EX latch
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [2:0]  mem_op_type_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_w_data_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    // byte-wide RAM port
    output logic [31:0] ram_a_o,
    output logic [7:0]  ram_dout_o,
    output logic        ram_wr_o,
    input  logic [7:0]  ram_din_i,
    // writeback
    output logic        wb_valid_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stall_o
);

    state_t      state;
    state_t      state_next;

    // Captured request.
    logic        is_load_q;
    logic [2:0]  funct3_q;
    logic [1:0]  last_idx;
    logic [31:0] addr_q;
    logic [4:0]  wd_q;
    logic        wreg_q;

    // Byte counter and "all load addresses issued" flag.
    logic [1:0]  cnt;
    logic        addr_done;

    // Store data shifts out of the bottom; load data shifts in at the top.
    logic [31:0] shreg;

    logic        accept;
    logic        sample;
    logic [31:0] load_result;
    logic [31:0] byte_addr;

    assign byte_addr = addr_q + {30'd0, cnt};

    load_ext u_load_ext (
        .raw    (align_load(shreg, last_idx)),
        .funct3 (funct3_q),
        .result (load_result)
    );

    // State register; reset aborts any transfer immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and all Moore outputs, so reset clears them at once.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        sample      = 1'b0;
        req_ready_o = 1'b0;
        stall_o     = 1'b1;
        ram_wr_o    = 1'b0;
        ram_a_o     = 32'h0000_0000;
        ram_dout_o  = 8'h00;
        wb_valid_o  = 1'b0;
        wd_o        = 5'd0;
        wreg_o      = 1'b0;
        wdata_o     = 32'h0000_0000;
        case (state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                stall_o     = 1'b0;
                if (req_valid_i) begin
                    accept = 1'b1;
                    if (is_store_i) begin
                        state_next = ST_STORE;
                    end else if (is_load_i) begin
                        state_next = ST_LOAD;
                    end else begin
                        state_next = ST_WB;
                    end
                end
            end
            ST_STORE: begin
                ram_wr_o   = 1'b1;
                ram_a_o    = byte_addr;
                ram_dout_o = shreg[7:0];
                if (cnt == last_idx) begin
                    state_next = ST_WB;
                end
            end
            ST_LOAD: begin
                // One cycle after the first address every cycle returns a
                // byte; the final cycle only collects the last byte.
                if (!addr_done) begin
                    ram_a_o = byte_addr;
                end
                sample = (cnt != 2'd0) || addr_done;
                if (addr_done) begin
                    state_next = ST_WB;
                end
            end
            ST_WB: begin
                wb_valid_o = 1'b1;
                wd_o       = wd_q;
                wreg_o     = wreg_q;
                wdata_o    = is_load_q ? load_result : addr_q;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request capture, byte counting and data shifting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_load_q <= 1'b0;
            funct3_q  <= 3'b000;
            last_idx  <= 2'd0;
            addr_q    <= 32'h0000_0000;
            wd_q      <= 5'd0;
            wreg_q    <= 1'b0;
            cnt       <= 2'd0;
            addr_done <= 1'b0;
            shreg     <= 32'h0000_0000;
        end else if (accept) begin
            is_load_q <= is_load_i && !is_store_i;
            funct3_q  <= mem_op_type_i;
            last_idx  <= last_byte_idx(mem_op_type_i);
            addr_q    <= wdata_i;
            wd_q      <= wd_i;
            // Stores never write back and x0 is never written.
            wreg_q    <= wreg_i && (wd_i != 5'd0) && !is_store_i;
            cnt       <= 2'd0;
            addr_done <= 1'b0;
            shreg     <= mem_w_data_i;
        end else if (state == ST_STORE) begin
            shreg <= {8'h00, shreg[31:8]};
            cnt   <= cnt + 2'd1;
        end else if (state == ST_LOAD) begin
            if (sample) begin
                shreg <= {ram_din_i, shreg[31:8]};
            end
            if (!addr_done) begin
                if (cnt == last_idx) begin
                    addr_done <= 1'b1;
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end
        end
    end

endmodule : mem_access
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Self-checking bench for mem_access with a byte RAM model and
//               a transaction-level reference for latency, RAM traffic and
//               writeback values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        is_load_i;
    logic        is_store_i;
    logic [2:0]  mem_op_type_i;
    logic [31:0] wdata_i;
    logic [31:0] mem_w_data_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] ram_a_o;
    logic [7:0]  ram_dout_o;
    logic        ram_wr_o;
    logic [7:0]  ram_din_i;
    logic        wb_valid_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stall_o;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    mem_access dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .is_load_i     (is_load_i),
        .is_store_i    (is_store_i),
        .mem_op_type_i (mem_op_type_i),
        .wdata_i       (wdata_i),
        .mem_w_data_i  (mem_w_data_i),
        .wd_i          (wd_i),
        .wreg_i        (wreg_i),
        .ram_a_o       (ram_a_o),
        .ram_dout_o    (ram_dout_o),
        .ram_wr_o      (ram_wr_o),
        .ram_din_i     (ram_din_i),
        .wb_valid_o    (wb_valid_o),
        .wd_o          (wd_o),
        .wreg_o        (wreg_o),
        .wdata_o       (wdata_o),
        .stall_o       (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte RAM: unwritten locations hold an address-derived pattern.
    logic [7:0] ram [logic [31:0]];

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction

    // Synchronous write, registered read (data valid one cycle after address).
    always @(posedge clk) begin
        if (ram_wr_o === 1'b1) ram[ram_a_o] = ram_dout_o;
        ram_din_i <= rd(ram_a_o);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    // Reference load value from current RAM contents.
    function automatic logic [31:0] expect_load(input logic [31:0] addr, input logic [2:0] f3);
        logic [31:0] v;
        logic [31:0] a;
        v = 32'h0;
        for (int k = 0; k < size_of(f3); k++) begin
            a = addr + 32'(k);
            v = v | (32'(rd(a)) << (8 * k));
        end
        if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    // One complete request: drive, follow every cycle, check against model.
    task automatic do_req(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] wd, input bit wr,
                          output logic [31:0] obs_wdata);
        int n, exp_lat, cyc, wb_cyc, nwr, stall_low;
        logic [31:0] exp_wdata;
        logic        exp_wreg;
        n         = size_of(f3);
        exp_lat   = st ? n + 1 : (ld ? n + 2 : 1);
        exp_wdata = ld ? expect_load(addr, f3) : addr;
        exp_wreg  = !st && wr && (wd != 5'd0);
        obs_wdata = 32'hx;
        chk("ready_idle", 32'(req_ready_o), 32'd1);
        req_valid_i   = 1'b1;
        is_load_i     = ld;
        is_store_i    = st;
        mem_op_type_i = f3;
        wdata_i       = addr;
        mem_w_data_i  = sdata;
        wd_i          = wd;
        wreg_i        = wr;
        @(posedge clk); #1;
        // Scramble inputs: the block must work from its captured copy.
        req_valid_i  = 1'b0;
        is_load_i    = 1'($urandom);
        is_store_i   = 1'($urandom);
        mem_op_type_i = 3'($urandom);
        wdata_i      = $urandom;
        mem_w_data_i = $urandom;
        wd_i         = 5'($urandom);
        wreg_i       = 1'($urandom);
        cyc = 1; wb_cyc = 0; nwr = 0; stall_low = 0;
        while (wb_cyc == 0 && cyc <= 12) begin
            if (stall_o !== 1'b1) stall_low++;
            if (ram_wr_o === 1'b1) begin
                chk("wr_addr", ram_a_o, addr + 32'(nwr));
                chk("wr_data", 32'(ram_dout_o), (sdata >> (8 * nwr)) & 32'hFF);
                nwr++;
            end
            if (ld && cyc <= n) chk("rd_addr", ram_a_o, addr + 32'(cyc - 1));
            if (wb_valid_o === 1'b1) begin
                wb_cyc = cyc;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("wb_latency", 32'(wb_cyc), 32'(exp_lat));
        chk("wr_count", 32'(nwr), st ? 32'(n) : 32'd0);
        chk("stall_busy", 32'(stall_low), 32'd0);
        if (wb_cyc != 0) begin
            obs_wdata = wdata_o;
            chk("wb_wd", 32'(wd_o), 32'(wd));
            chk("wb_wreg", 32'(wreg_o), 32'(exp_wreg));
            if (!st) chk("wb_wdata", wdata_o, exp_wdata);
            chk("wb_ram_a", ram_a_o, 32'h0);
            @(posedge clk); #1;
            chk("wb_pulse", 32'(wb_valid_o), 32'd0);
            chk("ready_after", 32'(req_ready_o), 32'd1);
        end
    endtask

    // Watchdog against a hung simulation.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] obs;
        logic [7:0]  old2;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          kind, cyc, bad;

        rst = 1'b0; req_valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
        mem_op_type_i = 3'b0; wdata_i = 32'h0; mem_w_data_i = 32'h0;
        wd_i = 5'd0; wreg_i = 1'b0;

        // Reset state.
        #12;
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_wr", 32'(ram_wr_o), 32'd0);
        chk("rst_wb", 32'(wb_valid_o), 32'd0);
        chk("rst_wreg", 32'(wreg_o), 32'd0);
        chk("rst_ram_a", ram_a_o, 32'h0);
        chk("rst_wdata", wdata_o, 32'h0);

        // Pass-through accepted on the first edge after reset release.
        @(negedge clk); rst = 1'b1;
        do_req(1'b0, 1'b0, 3'b010, 32'h7, 32'h0, 5'd3, 1'b1, obs);
        chk("pass_wdata", obs, 32'h7);
        do_req(1'b0, 1'b0, 3'b010, 32'h7, 32'h0, 5'd0, 1'b1, obs);

        // SW 0xDEADBEEF at 0x100.
        do_req(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd7, 1'b1, obs);
        chk("sw_mem", {rd(32'h103), rd(32'h102), rd(32'h101), rd(32'h100)}, 32'hDEADBEEF);

        // LB / LBU of 0x80.
        do_req(1'b0, 1'b1, 3'b000, 32'h200, 32'h0000_0080, 5'd1, 1'b1, obs);
        do_req(1'b1, 1'b0, 3'b000, 32'h200, 32'h0, 5'd5, 1'b1, obs);
        chk("lb_value", obs, 32'hFFFF_FF80);
        do_req(1'b1, 1'b0, 3'b100, 32'h200, 32'h0, 5'd5, 1'b1, obs);
        chk("lbu_value", obs, 32'h0000_0080);

        // LH across the top of the address space.
        do_req(1'b0, 1'b1, 3'b000, 32'hFFFF_FFFF, 32'h34, 5'd1, 1'b0, obs);
        do_req(1'b0, 1'b1, 3'b000, 32'h0000_0000, 32'h12, 5'd1, 1'b0, obs);
        do_req(1'b1, 1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 5'd6, 1'b1, obs);
        chk("lh_wrap_value", obs, 32'h0000_1234);

        // Reset during byte 2 of a word store.
        old2 = rd(32'h302);
        req_valid_i = 1'b1; is_store_i = 1'b1; is_load_i = 1'b0;
        mem_op_type_i = 3'b010; wdata_i = 32'h300; mem_w_data_i = 32'h44332211;
        wd_i = 5'd2; wreg_i = 1'b1;
        @(posedge clk); #1; req_valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_pre_wr", 32'(ram_wr_o), 32'd1);
        chk("abort_pre_addr", ram_a_o, 32'h302);
        #2 rst = 1'b0;
        #1;
        chk("abort_wr_async", 32'(ram_wr_o), 32'd0);
        chk("abort_ready", 32'(req_ready_o), 32'd1);
        chk("abort_stall", 32'(stall_o), 32'd0);
        chk("abort_ram_a", ram_a_o, 32'h0);
        @(negedge clk); rst = 1'b1;
        chk("abort_kept", {16'h0, rd(32'h301), rd(32'h300)}, 32'h2211);
        chk("abort_byte2", 32'(rd(32'h302)), 32'(old2));
        do_req(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd4, 1'b1, obs);

        // LW with request held high: second accept only after writeback.
        req_valid_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0;
        mem_op_type_i = 3'b010; wdata_i = 32'h100; wd_i = 5'd9; wreg_i = 1'b1;
        @(posedge clk); #1;
        bad = 0;
        for (int c = 1; c <= 6; c++) begin
            if (stall_o !== 1'b1) bad++;
            if (c < 6 && wb_valid_o !== 1'b0) bad++;
            if (c == 6) begin
                chk("held_wb", 32'(wb_valid_o), 32'd1);
                chk("held_wdata", wdata_o, 32'hDEADBEEF);
            end
            @(posedge clk); #1;
        end
        chk("held_stall_1to6", 32'(bad), 32'd0);
        chk("held_ready_c7", 32'(req_ready_o), 32'd1);
        @(posedge clk); #1;
        chk("held_second_acc", 32'(stall_o), 32'd1);
        req_valid_i = 1'b0;
        cyc = 1;
        while (wb_valid_o !== 1'b1 && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("held_second_lat", 32'(cyc), 32'd6);
        chk("held_second_data", wdata_o, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Randomized mix of pass-through, stores and loads.
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            f3   = 3'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 3) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            do_req(kind == 2, kind == 1, f3, addr, $urandom, 5'($urandom), 1'($urandom), obs);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mem_access
`default_nettype wire
